// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - AES InvSubBytes over a 128-bit state, BYTES_PER_CYCLE bytes per clock
// Optional feature macro INV_SBOX_REG_EN: registers the lookup outputs before the out_data write.
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = 8 * BYTES_PER_CYCLE;
  localparam logic [CW-1:0] LAST_GRP = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [127:0]  r_capture;
  logic [127:0]  r_out;
  logic [CW-1:0] r_cnt;
  logic [GW-1:0] w_grp_in;
  logic [GW-1:0] w_grp_out;
  logic [GW-1:0] w_wr_data;
  logic [CW-1:0] w_wr_idx;
  logic          w_wr_en;
  logic          w_cnt_step;
  logic          w_run_last;
  logic          w_accept;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  always_comb begin
    w_grp_in = '0;
    for (int g = 0; g < N; g++) begin
      if (r_cnt == CW'(g)) w_grp_in = r_capture[127 - g*GW -: GW];
    end
  end

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lut
    assign w_grp_out[GW-1-8*j -: 8] = inv_sbox(w_grp_in[GW-1-8*j -: 8]);
  end

  assign w_accept = (r_state == IDLE) && in_valid;

`ifdef INV_SBOX_REG_EN
  logic [GW-1:0] r_lut;
  logic [CW-1:0] r_lut_idx;
  logic          r_lut_vld;
  logic          r_issued_all;
  logic          w_lookup_en;

  // Lookups run for N cycles; the write stage trails by one, giving the extra drain cycle.
  assign w_lookup_en = (r_state == RUN) && !r_issued_all;
  assign w_cnt_step  = w_lookup_en;
  assign w_wr_en     = (r_state == RUN) && r_lut_vld;
  assign w_wr_idx    = r_lut_idx;
  assign w_wr_data   = r_lut;
  assign w_run_last  = w_wr_en && (r_lut_idx == LAST_GRP);

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_lut        <= '0;
      r_lut_idx    <= '0;
      r_lut_vld    <= 1'b0;
      r_issued_all <= 1'b0;
    end else begin
      r_lut_vld <= w_lookup_en;
      if (w_lookup_en) begin
        r_lut     <= w_grp_out;
        r_lut_idx <= r_cnt;
        if (r_cnt == LAST_GRP) r_issued_all <= 1'b1;
      end
    end
  end
`else
  assign w_cnt_step = (r_state == RUN);
  assign w_wr_en    = (r_state == RUN);
  assign w_wr_idx   = r_cnt;
  assign w_wr_data  = w_grp_out;
  assign w_run_last = w_wr_en && (r_cnt == LAST_GRP);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_cnt_step && (r_cnt != LAST_GRP)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_capture <= '0;
      r_out     <= '0;
    end else begin
      if (w_accept) r_capture <= in_data;
      if (w_wr_en) begin
        for (int g = 0; g < N; g++) begin
          if (w_wr_idx == CW'(g)) r_out[127 - g*GW -: GW] <= w_wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_run_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign out_data = r_out;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - scoreboard bench for inv_sub_bytes_seq
module tb_inv_sub_bytes_seq;
  parameter int BPC = 4;
  localparam int N = 16 / BPC;
`ifdef INV_SBOX_REG_EN
  localparam int LAT = N + 1;
`else
  localparam int LAT = N;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [7:0] fwd[256];
  logic [7:0] inv[256];
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [127:0] pd = '0;

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Forward S-box from a brute-force field inverse, then the inverse table by transposition.
  task automatic build_tables();
    logic [7:0] gi;
    logic [7:0] xb;
    for (int x = 0; x < 256; x++) begin
      xb = x[7:0];
      gi = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (tb_mul(xb, y[7:0]) == 8'h01) gi = y[7:0];
      end
      fwd[x] = gi ^ rotl(gi, 1) ^ rotl(gi, 2) ^ rotl(gi, 3) ^ rotl(gi, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv[fwd[x]] = x[7:0];
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv <= 1'b0;
    end else begin
      if (pv && !pr) begin
        check("valid_held", 128'(out_valid), 128'(1));
        check("data_stable", out_data, pd);
      end
      if (out_valid && !pv) begin
        if (sbq.size() == 0) check("unexpected_valid", 128'(1), 128'(0));
        else check("latency", 128'(cyc - sbq[0].acc), 128'(LAT));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", 128'(1), 128'(0));
        end else begin
          mon_e = sbq.pop_front();
          check("out_data", out_data, mon_e.data);
        end
      end
      pv <= out_valid;
      pr <= out_ready;
      pd <= out_data;
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int w;
    exp_t x;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && w < 500) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 128'(0), 128'(1));
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    x.data = e;
    x.acc  = cyc;
    sbq.push_back(x);
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() > 0 && w < 3000) begin
      w++;
      @(posedge clk);
      #1;
    end
    if (sbq.size() > 0) check("drain_timeout", 128'(sbq.size()), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int w;
    build_tables();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_out_data", out_data, 128'h0);
    @(posedge clk);
    #1;

    send(128'h63636363_63636363_63636363_63636363, 128'h0);
    send(128'h7C000000_00000000_00000000_00000016, 128'h01525252_52525252_52525252_525252FF);
    send(128'hED52637C_0016ED52_637C0016_ED52637C, 128'h53480001_52FF5348_000152FF_53480001);
    drain();

    for (int x = 0; x < 256; x++) begin
      b = x[7:0];
      send({16{b}}, {16{inv[b]}});
    end
    drain();

    // Backpressure: result must hold while a competing input is offered.
    out_ready = 1'b0;
    send(128'h00112233_44556677_8899AABB_CCDDEEFF,
         {inv[8'h00], inv[8'h11], inv[8'h22], inv[8'h33], inv[8'h44], inv[8'h55], inv[8'h66], inv[8'h77],
          inv[8'h88], inv[8'h99], inv[8'hAA], inv[8'hBB], inv[8'hCC], inv[8'hDD], inv[8'hEE], inv[8'hFF]});
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 200) begin
      w++;
      @(negedge clk);
    end
    check("hold_valid_seen", 128'(out_valid), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    repeat (10) begin
      @(negedge clk);
      check("hold_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("release_in_ready", 128'(in_ready), 128'(1));
    check("release_out_valid", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1;

    // Reset two cycles into RUN drops the block.
    out_ready = 1'b0;
    send(128'h01020304_05060708_090A0B0C_0D0E0F10, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'h0);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(128'h63636363_7C7C7C7C_00000000_16161616, 128'h00000000_01010101_52525252_FFFFFFFF);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
